// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_pkg
// Description : Shared types and constants for the seven-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF    = 7'h7F;
    localparam int   MAX_DIGITS = 8;

    // All-ones anode mask (every digit off) for a bank of `digits` slots.
    function automatic logic [MAX_DIGITS-1:0] an_off_mask(input int digits);
        an_off_mask = '0;
        for (int k = 0; k < MAX_DIGITS; k++) begin
            if (k < digits) begin
                an_off_mask[k] = 1'b1;
            end
        end
    endfunction

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/decoder_hex_16.sv
`default_nettype none
// ============================================================================
// Module      : decoder_hex_16
// Description : Combinational nibble to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_hex_16
    import hex_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    // Bit 0 = segment a ... bit 6 = segment g, 0 lights the segment.
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0:    o_seg = 7'h40;
            4'h1:    o_seg = 7'h79;
            4'h2:    o_seg = 7'h24;
            4'h3:    o_seg = 7'h30;
            4'h4:    o_seg = 7'h19;
            4'h5:    o_seg = 7'h12;
            4'h6:    o_seg = 7'h02;
            4'h7:    o_seg = 7'h78;
            4'h8:    o_seg = 7'h00;
            4'h9:    o_seg = 7'h18;
            4'hA:    o_seg = 7'h08;
            4'hB:    o_seg = 7'h03;
            4'hC:    o_seg = 7'h46;
            4'hD:    o_seg = 7'h21;
            4'hE:    o_seg = 7'h06;
            4'hF:    o_seg = 7'h0E;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : decoder_hex_16
`default_nettype wire

// File: rtl/hex_display_scanner.sv
`default_nettype none
// ============================================================================
// Module      : hex_display_scanner
// Description : Time-multiplexed, double-buffered seven-segment digit driver.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   blank,
    output logic                pending,
    output logic                done,
    output logic [DIGITS-1:0]   an,
    output seg_t                seg
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  c_idx_last = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] c_an_off   = DIGITS'(an_off_mask(DIGITS));

    logic [DIV_W-1:0]    r_div;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_stage;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_pending;
    logic                r_done;
    logic [DIGITS-1:0]   r_an;
    seg_t                r_seg;

    logic                w_div_wrap;
    logic                w_boundary;
    logic                w_commit;
    logic [3:0]          w_nibble;
    logic                w_blank_sel;
    logic [DIGITS-1:0]   w_an_lit;
    seg_t                w_dec_seg;

    assign w_div_wrap = (r_div == c_div_last);
    assign w_boundary = w_div_wrap && (r_idx == c_idx_last);
    assign w_commit   = w_boundary && r_pending;

    // Slot-select mux written as a compare loop so no index exceeds DIGITS.
    always_comb begin
        w_nibble    = 4'h0;
        w_blank_sel = 1'b0;
        w_an_lit    = c_an_off;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble    = r_disp[4*k +: 4];
                w_blank_sel = blank[k];
                w_an_lit[k] = 1'b0;
            end
        end
    end

    decoder_hex_16 u_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_stage   <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
            r_done    <= 1'b0;
            r_an      <= c_an_off;
            r_seg     <= SEG_OFF;
        end else begin
            if (w_div_wrap) begin
                r_div <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end

            // A load on the commit cycle lands in stage after the old stage
            // has moved to disp, so it remains pending for the next frame.
            if (w_commit) begin
                r_disp <= r_stage;
            end
            if (load) begin
                r_stage   <= value;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            r_done <= w_commit;

            // First cycle of every slot is dark to hide anode switching ghosts.
            if (r_div == '0) begin
                r_an  <= c_an_off;
                r_seg <= SEG_OFF;
            end else begin
                r_an  <= w_an_lit;
                r_seg <= w_blank_sel ? SEG_OFF : w_dec_seg;
            end
        end
    end

    assign pending = r_pending;
    assign done    = r_done;
    assign an      = r_an;
    assign seg     = r_seg;

endmodule : hex_display_scanner
`default_nettype wire
